inst_bus_arbiter: RTL and testbench
===================================

INST_BUS_ARBITER -- requirements
Module: inst_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive data-port grants allowed while a fetch waits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port if_req, input, 1, fetch-port read request; held until if_ack.
REQ-007 SHALL have port if_addr, input, ADDR_W, fetch-port byte address.
REQ-008 SHALL have port if_flush, input, 1, discards the outstanding fetch.
REQ-009 SHALL have port if_ack, output, 1, one-cycle pulse; if_rdata valid.
REQ-010 SHALL have port if_rdata, output, DATA_W, fetch read data.
REQ-011 SHALL have port dm_req, input, 1, data-port read request; held until dm_ack.
REQ-012 SHALL have port dm_addr, input, ADDR_W, data-port byte address.
REQ-013 SHALL have port dm_ack, output, 1, one-cycle pulse; dm_rdata valid.
REQ-014 SHALL have port dm_rdata, output, DATA_W, data read data.
REQ-015 SHALL have port mem_ce, output, 1, shared memory chip enable.
REQ-016 SHALL have port mem_addr, output, ADDR_W, shared memory address.
REQ-017 SHALL have port mem_rdata, input, DATA_W, shared memory read data.
REQ-018 SHALL have port mem_ready, input, 1, mem_rdata valid this cycle.
REQ-019 SHALL have port stall_req, output, 1, pipeline stall request.

Function
REQ-020 SHALL implement states IDLE, IF_BUSY, DM_BUSY, IF_DROP.
REQ-021 In IDLE with any request, SHALL grant and enter IF_BUSY or DM_BUSY at the next edge.
REQ-022 Grant priority SHALL be dm_req over if_req, except a waiting if_req SHALL win when burst_cnt equals MAX_BURST.
REQ-023 burst_cnt SHALL increment per DM grant while if_req is high, saturate at MAX_BURST, and clear on every IF grant or when if_req is low at a grant.
REQ-024 In IF_BUSY/DM_BUSY, mem_ce SHALL be 1 and mem_addr SHALL be the granted address latched at grant; otherwise mem_ce=0 and mem_addr=0.
REQ-025 On mem_ready in a BUSY state, SHALL register mem_rdata into the granted port's rdata, pulse its ack the following cycle, and return to IDLE.
REQ-026 The minimum latency SHALL be: request sampled at edge N, mem_ce high in cycle N..N+1, mem_ready in cycle N+1, ack high in cycle N+2.
REQ-027 In IDLE during the ack cycle, a new grant SHALL be permitted; the acked requester's req in that cycle SHALL be treated as a new request.
REQ-028 if_flush in IF_BUSY without mem_ready SHALL move the FSM to IF_DROP.
REQ-029 if_flush coincident with mem_ready in IF_BUSY SHALL suppress if_ack and return the FSM to IDLE.
REQ-030 IF_DROP SHALL keep mem_ce=1, wait for mem_ready, discard the data, produce no if_ack, and return to IDLE.
REQ-031 if_flush in IDLE or DM_BUSY SHALL have no effect.
REQ-032 if_rdata and dm_rdata SHALL hold their last value between acks.
REQ-033 stall_req SHALL equal (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
REQ-034 mem_ready outside a BUSY or IF_DROP state SHALL be ignored.

Reset
REQ-035 When rst=0, the FSM SHALL enter IDLE immediately regardless of clk, with burst_cnt=0, if_ack=0, dm_ack=0, mem_ce=0, mem_addr=0, if_rdata=0 and dm_rdata=0.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no ack; a mem_ready arriving after reset release SHALL be ignored.

Verification
REQ-037 Bench SHALL cover: if_req=1, if_addr=0x100, mem_ready one cycle after mem_ce, mem_rdata=0x3C010001 -> mem_addr=0x100; if_ack pulse 2 cycles after req; if_rdata=0x3C010001.
REQ-038 Bench SHALL cover: if_req and dm_req both high at once, dm_addr=0x200 -> DM granted first; IF granted in the IDLE cycle after dm_ack.
REQ-039 Bench SHALL cover: dm_req held high for 6 transactions with if_req high, MAX_BURST=4 -> exactly 4 dm_acks, then if_ack, then DM resumes.
REQ-040 Bench SHALL cover: if_flush pulsed in IF_BUSY, mem_ready delayed 3 cycles -> IF_DROP, mem_ce high until mem_ready, no if_ack, if_rdata unchanged.
REQ-041 Bench SHALL cover: rst=0 asserted mid DM_BUSY between clock edges -> mem_ce=0 immediately, no dm_ack; a late mem_ready after release is ignored.
REQ-042 Bench SHALL cover: stall_req checked against its equation every cycle across all the scenarios above.

Source files
------------

// File: rtl/inst_bus_arbiter.sv
// Arbitrates one shared single-port read memory between the fetch port and the data port.
// Data requests win by default; a fetch that has waited MAX_BURST data grants gets the next slot.
module inst_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_req
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] DM_BUSY = 2'd2;
  localparam logic [1:0] IF_DROP = 2'd3;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              fetch_starved;

  assign fetch_starved = if_req && (burst_cnt_q == BURST_LIMIT);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (dm_req && !fetch_starved) begin
          state_d = DM_BUSY;
          addr_d  = dm_addr;
          // The burst count only measures how long a pending fetch has been passed over.
          if (!if_req)
            burst_cnt_d = '0;
          else if (burst_cnt_q < BURST_LIMIT)
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else if (if_req) begin
          state_d     = IF_BUSY;
          addr_d      = if_addr;
          burst_cnt_d = '0;
        end
      end
      IF_BUSY: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (!if_flush) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (if_flush) begin
          state_d = IF_DROP;
        end
      end
      DM_BUSY: begin
        if (mem_ready) begin
          state_d    = IDLE;
          dm_ack_d   = 1'b1;
          dm_rdata_d = mem_rdata;
        end
      end
      IF_DROP: begin
        // The memory access is already in flight; let it finish and throw the data away.
        if (mem_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      addr_q      <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_ce    = (state_q != IDLE);
  assign mem_addr  = mem_ce ? addr_q : '0;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_req = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_inst_bus_arbiter.sv
// Bench for inst_bus_arbiter: directed scenarios plus randomized traffic, all compared every
// cycle against a transaction-level model of the arbitration rules.
module tb_inst_bus_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, mem_ready = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0, dm_addr = '0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              if_ack, dm_ack, mem_ce, stall_req;
  logic [DATA_W-1:0] if_rdata, dm_rdata;
  logic [ADDR_W-1:0] mem_addr;

  inst_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: at most one memory access in flight, owned by one port.
  logic              m_active, m_fetch, m_dropped, m_if_ack, m_dm_ack;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_if_rdata, m_dm_rdata;
  int                m_burst;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0; m_fetch <= 1'b0; m_dropped <= 1'b0;
      m_if_ack <= 1'b0; m_dm_ack <= 1'b0; m_addr <= '0;
      m_if_rdata <= '0; m_dm_rdata <= '0; m_burst <= 0;
    end else begin
      m_if_ack <= 1'b0;
      m_dm_ack <= 1'b0;
      if (!m_active) begin
        if (dm_req && !(if_req && m_burst == MAX_BURST)) begin
          m_active <= 1'b1; m_fetch <= 1'b0; m_dropped <= 1'b0; m_addr <= dm_addr;
          m_burst  <= if_req ? ((m_burst < MAX_BURST) ? m_burst + 1 : MAX_BURST) : 0;
        end else if (if_req) begin
          m_active <= 1'b1; m_fetch <= 1'b1; m_dropped <= 1'b0; m_addr <= if_addr;
          m_burst  <= 0;
        end
      end else if (mem_ready) begin
        m_active <= 1'b0;
        if (!m_fetch) begin
          m_dm_ack <= 1'b1; m_dm_rdata <= mem_rdata;
        end else if (!m_dropped && !if_flush) begin
          m_if_ack <= 1'b1; m_if_rdata <= mem_rdata;
        end
      end else if (m_fetch && if_flush) begin
        m_dropped <= 1'b1;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (chk_on) begin
      check("if_ack",    {63'd0, if_ack},    {63'd0, m_if_ack});
      check("dm_ack",    {63'd0, dm_ack},    {63'd0, m_dm_ack});
      check("if_rdata",  64'(if_rdata),      64'(m_if_rdata));
      check("dm_rdata",  64'(dm_rdata),      64'(m_dm_rdata));
      check("mem_ce",    {63'd0, mem_ce},    {63'd0, m_active});
      check("mem_addr",  64'(mem_addr),      m_active ? 64'(m_addr) : 64'd0);
      check("stall_req", {63'd0, stall_req},
            {63'd0, (if_req & ~m_if_ack) | (dm_req & ~m_dm_ack)});
    end
  end

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    int dm_cnt, if_cnt, dm_before, dm_after;
    #1 rst = 1'b0;
    chk_on = 1'b1;
    next(); next();
    check("rst_mem_ce",   {63'd0, mem_ce}, 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_if_ack",   {63'd0, if_ack}, 64'd0);
    check("rst_dm_ack",   {63'd0, dm_ack}, 64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_dm_rdata", 64'(dm_rdata), 64'd0);
    rst = 1'b1;
    next();

    // Single fetch at minimum latency.
    if_req = 1'b1; if_addr = 32'h100;
    next();
    check("fetch_ce",   {63'd0, mem_ce}, 64'd1);
    check("fetch_addr", 64'(mem_addr), 64'h100);
    mem_ready = 1'b1; mem_rdata = 32'h3C01_0001;
    next();
    check("fetch_ack",   {63'd0, if_ack}, 64'd1);
    check("fetch_rdata", 64'(if_rdata), 64'h3C01_0001);
    if_req = 1'b0; mem_ready = 1'b0;
    next();
    check("fetch_ack_pulse", {63'd0, if_ack}, 64'd0);

    // Simultaneous requests: data port first, fetch granted from the ack cycle.
    if_req = 1'b1; if_addr = 32'h104; dm_req = 1'b1; dm_addr = 32'h200;
    next();
    check("both_dm_addr", 64'(mem_addr), 64'h200);
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    next();
    check("both_dm_ack",   {63'd0, dm_ack}, 64'd1);
    check("both_dm_rdata", 64'(dm_rdata), 64'h0BAD_F00D);
    dm_req = 1'b0; mem_ready = 1'b0;
    next();
    check("both_if_addr", 64'(mem_addr), 64'h104);
    mem_ready = 1'b1; mem_rdata = 32'h0000_1234;
    next();
    check("both_if_ack", {63'd0, if_ack}, 64'd1);
    if_req = 1'b0; mem_ready = 1'b0;
    next();

    // Data-port burst against a waiting fetch.
    dm_req = 1'b1; dm_addr = 32'h500; if_req = 1'b1; if_addr = 32'h600;
    mem_ready = 1'b1;
    dm_cnt = 0; if_cnt = 0; dm_before = 0; dm_after = 0;
    for (int c = 0; c < 60 && (dm_req || if_req); c++) begin
      next();
      mem_rdata = $urandom;
      if (dm_ack) begin
        dm_cnt++;
        if (if_cnt == 0) dm_before++; else dm_after++;
        if (dm_cnt == 6) dm_req = 1'b0; else dm_addr = dm_addr + 32'd4;
      end
      if (if_ack) begin
        if_cnt++;
        if_req = 1'b0;
      end
    end
    check("burst_dm_before_if", 64'(dm_before), 64'd4);
    check("burst_if_count",     64'(if_cnt),    64'd1);
    check("burst_dm_after_if",  64'(dm_after),  64'd2);
    check("burst_dm_total",     64'(dm_cnt),    64'd6);
    dm_req = 1'b0; if_req = 1'b0;
    repeat (3) next();
    mem_ready = 1'b0;
    next();

    // Flushed fetch with a slow memory.
    if_req = 1'b1; if_addr = 32'h300;
    next();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    next();
    if_req = 1'b0; mem_ready = 1'b0;
    next();
    if_req = 1'b1; if_addr = 32'h304;
    next();
    if_flush = 1'b1; if_req = 1'b0;
    next();
    if_flush = 1'b0;
    check("drop_ce_1", {63'd0, mem_ce}, 64'd1);
    next();
    check("drop_ce_2", {63'd0, mem_ce}, 64'd1);
    next();
    check("drop_ce_3", {63'd0, mem_ce}, 64'd1);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    next();
    check("drop_no_ack", {63'd0, if_ack}, 64'd0);
    check("drop_ce_off", {63'd0, mem_ce}, 64'd0);
    check("drop_rdata",  64'(if_rdata), 64'hCAFE_F00D);
    mem_ready = 1'b0;
    next();

    // Asynchronous reset in the middle of a data access.
    dm_req = 1'b1; dm_addr = 32'h400;
    next();
    check("rstmid_ce_before", {63'd0, mem_ce}, 64'd1);
    #4 rst = 1'b0;
    #1;
    check("rstmid_ce",   {63'd0, mem_ce}, 64'd0);
    check("rstmid_addr", 64'(mem_addr), 64'd0);
    check("rstmid_ack",  {63'd0, dm_ack}, 64'd0);
    dm_req = 1'b0;
    next();
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    next();
    check("rstmid_late_ack",   {63'd0, dm_ack}, 64'd0);
    check("rstmid_late_ce",    {63'd0, mem_ce}, 64'd0);
    check("rstmid_late_rdata", 64'(dm_rdata), 64'd0);
    mem_ready = 1'b0;
    next();

    // Randomized traffic; requesters react to the model's acks.
    for (int c = 0; c < 3000; c++) begin
      next();
      mem_ready = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      if_flush  = 1'b0;
      if (dm_req && m_dm_ack) begin
        if ($urandom_range(0, 1) == 1) dm_addr = $urandom & 32'hFFFF_FFFC;
        else dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1'b1; dm_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (if_req && m_if_ack) begin
        if ($urandom_range(0, 1) == 1) if_addr = $urandom & 32'hFFFF_FFFC;
        else if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (if_req && $urandom_range(0, 11) == 0) begin
        if_flush = 1'b1; if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 15) == 0) begin
        if_flush = 1'b1;
      end
    end
    if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0; mem_ready = 1'b1;
    repeat (4) next();
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
